// File: rtl/score_display_if.sv
// score_display_if: request/result bundle (start, score, busy, done, overflow, bcd, hex) between score source and display driver
interface score_display_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      score;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   hex;
  modport master (output start, score, input busy, done, overflow, bcd, hex);
  modport slave  (input start, score, output busy, done, overflow, bcd, hex);
endinterface

// File: rtl/score_display_seq.sv
// score_display_seq: iterative binary-to-BCD converter with registered active-low 7-segment outputs (clk, reset, bus: start/score in; busy/done/overflow/bcd/hex out)
module score_display_seq #(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input logic             clk,
  input logic             reset,
  score_display_if.slave  bus
);
  localparam int AW = 4*DIGITS + 4;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state, state_n;
  logic [BIN_W-1:0]    shreg, pend_val;
  logic [AW-1:0]       acc, adj;
  logic [CW-1:0]       cnt;
  logic                pend, sticky, take, ov, z;
  logic [4*DIGITS-1:0] dig;
  logic [7*DIGITS-1:0] hx;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h18;
      default: seg = 7'h7f;
    endcase
  endfunction
  // a pending request is served from IDLE without waiting for another start
  assign take = (state == IDLE) && (bus.start || pend);
  assign bus.busy = (state != IDLE) || pend || bus.done;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = take ? SHIFT : IDLE;
      SHIFT:   state_n = (cnt == CW'(BIN_W - 1)) ? LOAD : SHIFT;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    adj = acc;
    for (int k = 0; k <= DIGITS; k++)
      adj[4*k+:4] = (acc[4*k+:4] >= 4'd5) ? acc[4*k+:4] + 4'd3 : acc[4*k+:4];
  end
  // sticky catches BCD bits lost off the top when BIN_W far exceeds DIGITS
  always_comb begin
    ov = sticky || (acc[AW-1-:4] != 4'd0);
    z = 1'b1;
    dig = '0;
    hx = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z = z && (acc[4*k+:4] == 4'd0);
      dig[4*k+:4] = ov ? 4'h9 : acc[4*k+:4];
      hx[7*k+:7] = ((BLANK_LZ != 0) && z && (k != 0) && !ov) ? 7'h7f : seg(dig[4*k+:4]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      acc <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      pend <= 1'b0;
      pend_val <= '0;
      bus.done <= 1'b0;
      bus.overflow <= 1'b0;
      bus.bcd <= '0;
      for (int k = 0; k < DIGITS; k++)
        bus.hex[7*k+:7] <= ((k > 0) && (BLANK_LZ != 0)) ? 7'h7f : 7'h40;
    end else begin
      state <= state_n;
      bus.done <= (state == LOAD);
      if (take) begin
        shreg <= pend ? pend_val : bus.score;
        acc <= '0;
        cnt <= '0;
        sticky <= 1'b0;
      end
      if (bus.start && ((state != IDLE) || pend)) begin
        pend <= 1'b1;
        pend_val <= bus.score;
      end else if (take) begin
        pend <= 1'b0;
      end
      if (state == SHIFT) begin
        acc <= {adj[AW-2:0], shreg[BIN_W-1]};
        shreg <= shreg << 1;
        cnt <= cnt + CW'(1);
        sticky <= sticky || adj[AW-1];
      end
      if (state == LOAD) begin
        bus.overflow <= ov;
        bus.bcd <= dig;
        bus.hex <= hx;
      end
    end
  end
endmodule

// File: tb/tb_score_display_seq.sv
// tb_score_display_seq: table, corner-sequence and randomized checks of score_display_seq variants
module tb_score_display_seq;
  logic clk = 1'b0;
  logic reset, reset4, st;
  logic [7:0] sc;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  localparam logic [6:0] SEGT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
  score_display_if #(.BIN_W(8),  .DIGITS(3)) ia ();
  score_display_if #(.BIN_W(8),  .DIGITS(2)) ib ();
  score_display_if #(.BIN_W(8),  .DIGITS(3)) ic ();
  score_display_if #(.BIN_W(16), .DIGITS(5)) id ();
  assign ia.start = st;
  assign ib.start = st;
  assign ic.start = st;
  assign ia.score = sc;
  assign ib.score = sc;
  assign ic.score = sc;
  score_display_seq #(.BIN_W(8),  .DIGITS(3), .BLANK_LZ(1)) d1 (.clk(clk), .reset(reset),  .bus(ia));
  score_display_seq #(.BIN_W(8),  .DIGITS(2), .BLANK_LZ(1)) d2 (.clk(clk), .reset(reset),  .bus(ib));
  score_display_seq #(.BIN_W(8),  .DIGITS(3), .BLANK_LZ(0)) d3 (.clk(clk), .reset(reset),  .bus(ic));
  score_display_seq #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1)) d4 (.clk(clk), .reset(reset4), .bus(id));
  typedef struct {
    logic [7:0]  sc;
    logic [11:0] b3;
    logic [20:0] h3;
    logic [7:0]  b2;
    logic [13:0] h2;
    logic        o2;
    logic [20:0] hn;
  } vec_t;
  typedef struct {
    int          t;
    int unsigned v;
  } exp_t;
  vec_t tv [8];
  exp_t q [$];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void ref_out(input int unsigned v, input int nd, input bit bl,
                                  output logic [31:0] b, output logic [63:0] h, output bit o);
    int unsigned lim, p;
    int d;
    lim = 1;
    for (int k = 0; k < nd; k++) lim *= 10;
    o = v >= lim;
    b = '0;
    h = '0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      d = o ? 9 : int'((v / p) % 10);
      b[4*k+:4] = 4'(d);
      h[7*k+:7] = (bl && !o && k > 0 && v < p) ? 7'h7f : SEGT[d];
      p *= 10;
    end
  endfunction
  initial begin
    int n, seen, free_at, e;
    int at [2];
    logic [11:0] bv [2];
    bit pend, s, o, ed, dflag;
    int unsigned pval, v;
    logic [31:0] rb;
    logic [63:0] rh;
    tv[0] = '{8'd0,   12'h000, {7'h7f,7'h7f,7'h40}, 8'h00, {7'h7f,7'h40}, 1'b0, {7'h40,7'h40,7'h40}};
    tv[1] = '{8'd255, 12'h255, {7'h24,7'h12,7'h12}, 8'h99, {7'h18,7'h18}, 1'b1, {7'h24,7'h12,7'h12}};
    tv[2] = '{8'd7,   12'h007, {7'h7f,7'h7f,7'h78}, 8'h07, {7'h7f,7'h78}, 1'b0, {7'h40,7'h40,7'h78}};
    tv[3] = '{8'd40,  12'h040, {7'h7f,7'h19,7'h40}, 8'h40, {7'h19,7'h40}, 1'b0, {7'h40,7'h19,7'h40}};
    tv[4] = '{8'd99,  12'h099, {7'h7f,7'h18,7'h18}, 8'h99, {7'h18,7'h18}, 1'b0, {7'h40,7'h18,7'h18}};
    tv[5] = '{8'd100, 12'h100, {7'h79,7'h40,7'h40}, 8'h99, {7'h18,7'h18}, 1'b1, {7'h79,7'h40,7'h40}};
    tv[6] = '{8'd205, 12'h205, {7'h24,7'h40,7'h12}, 8'h99, {7'h18,7'h18}, 1'b1, {7'h24,7'h40,7'h12}};
    tv[7] = '{8'd10,  12'h010, {7'h7f,7'h79,7'h40}, 8'h10, {7'h79,7'h40}, 1'b0, {7'h40,7'h79,7'h40}};
    reset = 1'b1;
    reset4 = 1'b1;
    st = 1'b0;
    sc = '0;
    id.start = 1'b0;
    id.score = '0;
    repeat (3) step();
    reset = 1'b0;
    reset4 = 1'b0;
    step();
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_ovf", ia.overflow, 0);
    chk("rst_bcd", ia.bcd, 0);
    chk("rst_hex", ia.hex, {7'h7f, 7'h7f, 7'h40});
    chk("rst_hex_b", ib.hex, {7'h7f, 7'h40});
    chk("rst_hex_noblank", ic.hex, {7'h40, 7'h40, 7'h40});
    chk("rst_hex_d4", id.hex, {7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h40});
    for (int i = 0; i < 8; i++) begin
      st = 1'b1;
      sc = tv[i].sc;
      step();
      st = 1'b0;
      n = 0;
      while (!ia.done && n < 20) begin
        step();
        n++;
      end
      chk("tbl_latency", n, 9);
      chk("tbl_done_b", ib.done, 1);
      chk("tbl_bcd", ia.bcd, tv[i].b3);
      chk("tbl_hex", ia.hex, tv[i].h3);
      chk("tbl_ovf", ia.overflow, 0);
      chk("tbl_bcd_d2", ib.bcd, tv[i].b2);
      chk("tbl_hex_d2", ib.hex, tv[i].h2);
      chk("tbl_ovf_d2", ib.overflow, tv[i].o2);
      chk("tbl_hex_noblank", ic.hex, tv[i].hn);
      step();
      chk("tbl_busy_after", ia.busy, 0);
      chk("tbl_done_after", ia.done, 0);
      chk("tbl_hold", ia.bcd, tv[i].b3);
    end
    st = 1'b1; sc = 8'd12; step();
    st = 1'b0; step(); step();
    st = 1'b1; sc = 8'd34; step();
    st = 1'b0; step();
    st = 1'b1; sc = 8'd56; step();
    st = 1'b0;
    seen = 0;
    at[0] = -1; at[1] = -1;
    bv[0] = '0; bv[1] = '0;
    for (int k = 6; k <= 24; k++) begin
      step();
      if (ia.done) begin
        if (seen < 2) begin
          at[seen] = k;
          bv[seen] = ia.bcd;
        end
        seen++;
      end
    end
    chk("t5_done_count", seen, 2);
    chk("t5_first_at", at[0], 9);
    chk("t5_first_bcd", bv[0], 12'h012);
    chk("t5_second_at", at[1], 19);
    chk("t5_second_bcd", bv[1], 12'h056);
    id.start = 1'b1; id.score = 16'd65535; step();
    id.start = 1'b0; repeat (3) step();
    reset4 = 1'b1; step();
    reset4 = 1'b0;
    dflag = 1'b0;
    repeat (20) begin
      step();
      if (id.done) dflag = 1'b1;
    end
    chk("t6_no_done", dflag, 0);
    chk("t6_rst_bcd", id.bcd, 0);
    chk("t6_rst_hex", id.hex, {7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h40});
    chk("t6_rst_busy", id.busy, 0);
    id.start = 1'b1; id.score = 16'd65535; step();
    id.start = 1'b0;
    n = 0;
    while (!id.done && n < 40) begin
      step();
      n++;
    end
    chk("t6_latency", n, 17);
    chk("t6_bcd", id.bcd, 20'h65535);
    chk("t6_hex", id.hex, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
    chk("t6_ovf", id.overflow, 0);
    repeat (3) step();
    free_at = 0;
    pend = 1'b0;
    pval = 0;
    for (e = 0; e < 700; e++) begin
      s = (e < 640) && ($urandom_range(0, 5) == 0);
      v = $urandom_range(0, 255);
      st = s;
      sc = 8'(v);
      step();
      if (e >= free_at && (pend || s)) begin
        q.push_back('{e + 9, pend ? pval : v});
        free_at = e + 10;
        if (pend) begin
          pend = s;
          pval = v;
        end
      end else if (s) begin
        pend = 1'b1;
        pval = v;
      end
      ed = q.size() > 0 && q[0].t == e;
      chk("rnd_done", ia.done, ed);
      if (ed) begin
        ref_out(q[0].v, 3, 1'b1, rb, rh, o);
        chk("rnd_bcd", ia.bcd, rb);
        chk("rnd_hex", ia.hex, rh);
        chk("rnd_ovf", ia.overflow, o);
        ref_out(q[0].v, 2, 1'b1, rb, rh, o);
        chk("rnd_bcd_d2", ib.bcd, rb);
        chk("rnd_hex_d2", ib.hex, rh);
        chk("rnd_ovf_d2", ib.overflow, o);
        ref_out(q[0].v, 3, 1'b0, rb, rh, o);
        chk("rnd_hex_noblank", ic.hex, rh);
        void'(q.pop_front());
      end
    end
    chk("rnd_queue_empty", q.size(), 0);
    chk("rnd_pending_empty", pend, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
